// File: rtl/seq_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, W-cycle latency.
// Define DIVIDER_SIGNED_EN for two's-complement operands (truncating division).
module seq_divider #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] Q,
    output logic [W-1:0] R,
    output logic         dbz
);

    localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   dvd_q, dvd_d;
    logic [W-1:0]   dvs_q, dvs_d;
    logic [W-1:0]   rem_q, rem_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   q_q, q_d;
    logic [W-1:0]   r_q, r_d;
    logic           dbz_q, dbz_d;

    logic [W:0]     rem_sh, trial;
    logic [W-1:0]   dvd_sh, rem_step;
    logic [W-1:0]   a_mag, b_mag, q_fin, r_fin;

    // The stored remainder is always < divisor, so W bits suffice; the
    // shifted value and the trial subtraction are still carried at W+1 bits.
    always_comb begin
        rem_sh   = {rem_q, dvd_q[W-1]};
        trial    = rem_sh - {1'b0, dvs_q};
        dvd_sh   = {dvd_q[W-2:0], ~trial[W]};
        rem_step = trial[W] ? rem_sh[W-1:0] : trial[W-1:0];
    end

`ifdef DIVIDER_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    always_comb begin
        a_mag = A[W-1] ? -A : A;
        b_mag = B[W-1] ? -B : B;
        q_fin = negq_q ? -dvd_sh : dvd_sh;
        r_fin = negr_q ? -rem_step : rem_step;
    end
`else
    always_comb begin
        a_mag = A;
        b_mag = B;
        q_fin = dvd_sh;
        r_fin = rem_step;
    end
`endif

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        negq_d  = negq_q;
        negr_d  = negr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    if (B == '0) begin
                        state_d = S_DONE;
                        q_d     = '1;
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        dvs_d   = b_mag;
                        dvd_d   = a_mag;
                        rem_d   = '0;
                        cnt_d   = '0;
`ifdef DIVIDER_SIGNED_EN
                        negq_d  = A[W-1] ^ B[W-1];
                        negr_d  = A[W-1];
`endif
                    end
                end
            end
            S_RUN: begin
                dvd_d = dvd_sh;
                rem_d = rem_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W-1)) begin
                    state_d = S_DONE;
                    q_d     = q_fin;
                    r_d     = r_fin;
                    dbz_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            negq_q  <= negq_d;
            negr_q  <= negr_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign Q    = q_q;
    assign R    = r_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (W=8): directed cases plus a random sweep
// against a plain-arithmetic reference; honours DIVIDER_SIGNED_EN when defined.
module tb_seq_divider;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [W-1:0] A, B;
    logic         busy, done, dbz;
    logic [W-1:0] Q, R;

    int total = 0;
    int bad   = 0;

    seq_divider #(.W(W)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .Q      (Q),
        .R      (R),
        .dbz    (dbz)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic z);
`ifdef DIVIDER_SIGNED_EN
        int sa, sb;
`endif
        if (b == 8'd0) begin
            q = 8'hFF;
            r = a;
            z = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            sa = int'($signed(a));
            sb = int'($signed(b));
            q  = 8'(sa / sb);
            r  = 8'(sa % sb);
`else
            q  = a / b;
            r  = a % b;
`endif
            z = 1'b0;
        end
    endfunction

    // Issues a start from a negedge and returns at the negedge where done is
    // high. edge_idx: clock edge (edge 0 = accepting edge) that raised done,
    // -1 on timeout. busy_cnt: sampled cycles with busy high before done.
    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int edge_idx, output int busy_cnt);
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        A        = 8'($urandom);
        B        = 8'($urandom);
        edge_idx = -1;
        busy_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                edge_idx = n - 1;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        #12;
        total++;
        if ({busy, done, Q, R, dbz} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b Q=%h R=%h dbz=%b want all 0",
                     busy, done, Q, R, dbz);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e, bc;
        logic [7:0] eq, er;
        logic ez;
        model(8'd200, 8'd7, eq, er, ez);
        run_div(8'd200, 8'd7, e, bc);
        total++;
        if (e !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", e); end
        total++;
        if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", bc); end
        total++;
        if ({Q, R, dbz} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL basic_result got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=%b", Q, R, dbz, eq, er, ez);
        end
`ifndef DIVIDER_SIGNED_EN
        total++;
        if ({Q, R} !== {8'h1C, 8'd4}) begin
            bad++;
            $display("FAIL basic_const got Q=%h R=%h want Q=1c R=04", Q, R);
        end
`endif
        @(negedge clk);
        total++;
        if ({done, busy, Q, R, dbz} !== {2'b00, eq, er, ez}) begin
            bad++;
            $display("FAIL basic_hold got done=%b busy=%b Q=%h R=%h want done=0 busy=0 Q=%h R=%h",
                     done, busy, Q, R, eq, er);
        end
    endtask

    task automatic test_back_to_back();
        int e, bc;
        logic [7:0] eq, er;
        logic ez;
        @(negedge clk);
        model(8'd5, 8'd9, eq, er, ez);
        run_div(8'd5, 8'd9, e, bc);
        total++;
        if ({Q, R, dbz} !== {eq, er, ez} || e !== 8) begin
            bad++;
            $display("FAIL b2b_first got Q=%h R=%h dbz=%b edge=%0d want Q=%h R=%h dbz=%b edge=8",
                     Q, R, dbz, e, eq, er, ez);
        end
        model(8'd255, 8'd1, eq, er, ez);
        run_div(8'd255, 8'd1, e, bc);
        total++;
        if (e !== 8) begin bad++; $display("FAIL b2b_latency got=%0d want=8", e); end
        total++;
        if ({Q, R, dbz} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL b2b_second got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=%b", Q, R, dbz, eq, er, ez);
        end
    endtask

    task automatic test_div_by_zero();
        int e, bc;
        logic [7:0] eq, er;
        logic ez;
        @(negedge clk);
        run_div(8'd77, 8'd0, e, bc);
        total++;
        if (e !== 0 || bc !== 0) begin
            bad++;
            $display("FAIL dbz_timing got edge=%0d busy_cycles=%0d want edge=0 busy_cycles=0", e, bc);
        end
        total++;
        if ({Q, R, dbz, busy} !== {8'hFF, 8'd77, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL dbz_result got Q=%h R=%h dbz=%b busy=%b want Q=ff R=4d dbz=1 busy=0", Q, R, dbz, busy);
        end
        model(8'd100, 8'd10, eq, er, ez);
        run_div(8'd100, 8'd10, e, bc);
        total++;
        if ({Q, R, dbz} !== {eq, er, ez} || e !== 8) begin
            bad++;
            $display("FAIL dbz_clear got Q=%h R=%h dbz=%b edge=%0d want Q=%h R=%h dbz=0 edge=8",
                     Q, R, dbz, e, eq, er);
        end
    endtask

    task automatic test_start_ignored();
        int e;
        logic [7:0] eq, er;
        logic ez;
        @(negedge clk);
        model(8'd200, 8'd7, eq, er, ez);
        A = 8'd200; B = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done) begin
                e = n - 1;
                break;
            end
            start = (n == 3);
            A     = 8'd13;
            B     = 8'd3;
        end
        start = 1'b0;
        total++;
        if (e !== 8 || {Q, R, dbz} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL ignore_start got edge=%0d Q=%h R=%h dbz=%b want edge=8 Q=%h R=%h dbz=%b",
                     e, Q, R, dbz, eq, er, ez);
        end
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) begin
            bad++;
            $display("FAIL ignore_after got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_reset_abort();
        int e, bc, seen;
        logic [7:0] eq, er;
        logic ez;
        @(negedge clk);
        A = 8'd250; B = 8'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, Q, R, dbz} !== '0) begin
            bad++;
            $display("FAIL abort_async got busy=%b done=%b Q=%h R=%h dbz=%b want all 0", busy, done, Q, R, dbz);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++;
            $display("FAIL abort_no_done got active_cycles=%0d want 0", seen);
        end
        model(8'd250, 8'd3, eq, er, ez);
        run_div(8'd250, 8'd3, e, bc);
        total++;
        if (e !== 8 || {Q, R, dbz} !== {eq, er, ez}) begin
            bad++;
            $display("FAIL abort_recover got edge=%0d Q=%h R=%h want edge=8 Q=%h R=%h", e, Q, R, eq, er);
        end
    endtask

`ifdef DIVIDER_SIGNED_EN
    task automatic test_signed();
        int e, bc;
        logic [7:0] va [4] = '{8'h9C, 8'h64, 8'h80, 8'hFB};
        logic [7:0] vb [4] = '{8'h07, 8'hF9, 8'hFF, 8'h00};
        logic [7:0] vq [4] = '{8'hF2, 8'hF2, 8'h80, 8'hFF};
        logic [7:0] vr [4] = '{8'hFE, 8'h02, 8'h00, 8'hFB};
        logic       vz [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            run_div(va[i], vb[i], e, bc);
            total++;
            if ({Q, R, dbz} !== {vq[i], vr[i], vz[i]}) begin
                bad++;
                $display("FAIL signed_%0d got Q=%h R=%h dbz=%b want Q=%h R=%h dbz=%b",
                         i, Q, R, dbz, vq[i], vr[i], vz[i]);
            end
        end
    endtask
`endif

    task automatic test_random();
        int e, bc;
        logic [7:0] a, b, eq, er;
        logic ez;
        @(negedge clk);
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0:       a = 8'h00;
                1:       a = 8'h80;
                2:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0:       b = 8'h01;
                1:       b = 8'hFF;
                2:       b = 8'h80;
                default: b = 8'($urandom_range(1, 255));
            endcase
            model(a, b, eq, er, ez);
            run_div(a, b, e, bc);
            total++;
            if (e !== 8 || {Q, R, dbz} !== {eq, er, ez}) begin
                bad++;
                $display("FAIL random a=%h b=%h got edge=%0d Q=%h R=%h dbz=%b want edge=8 Q=%h R=%h dbz=%b",
                         a, b, e, Q, R, dbz, eq, er, ez);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_div_by_zero();
        test_start_ignored();
        test_reset_abort();
`ifdef DIVIDER_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
